// File: rtl/rca_pkg.sv
// Shared definitions for the segmented, pipelined ripple-carry adder/subtractor.
package rca_pkg;

    // Per-beat control and status bits that travel alongside the partial sum.
    typedef struct packed {
        logic sub;    // beat is a subtraction (B already inverted upstream)
        logic carry;  // carry out of the most recently added segment
        logic ovf;    // carry-into-MSB xor carry-out-of-MSB of that segment
    } stage_flags_t;

    // Number of segments, which is also the number of pipeline stages.
    function automatic int nseg(input int width, input int seg);
        return (seg > 0) ? (width / seg) : 0;
    endfunction

    // Operands must split into a whole number of segments.
    function automatic bit seg_fits(input int width, input int seg);
        return (seg > 0) && (width >= seg) && ((width % seg) == 0);
    endfunction

endpackage

// File: rtl/rca_seg.sv
// Combinational SEG-bit ripple-carry adder slice; one slice per pipeline stage.
module rca_seg #(
    parameter int SEG = 8
) (
    input  logic [SEG-1:0] a_i,
    input  logic [SEG-1:0] b_i,
    input  logic           c_i,
    output logic [SEG-1:0] sum_o,
    output logic           c_o,
    output logic           c_msb_o
);

    logic [SEG:0] carry;

    // Bit-serial ripple through the slice; carry[i] is the carry into bit i.
    always_comb begin
        carry    = '0;
        sum_o    = '0;
        carry[0] = c_i;
        for (int i = 0; i < SEG; i++) begin
            sum_o[i]     = a_i[i] ^ b_i[i] ^ carry[i];
            carry[i + 1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
        end
    end

    assign c_o     = carry[SEG];
    assign c_msb_o = carry[SEG-1];

endmodule

// File: rtl/rca_pipe.sv
// Pipelined ripple-carry adder/subtractor: one SEG-bit ripple per stage, carry
// registered between stages, skid-free valid/ready chain that collapses bubbles.
module rca_pipe
    import rca_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SEG   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    localparam int NSEG = nseg(WIDTH, SEG);

    if (!seg_fits(WIDTH, SEG)) begin : g_bad_params
        $error("rca_pipe: WIDTH (%0d) must be a non-zero multiple of SEG (%0d)", WIDTH, SEG);
    end

    // Stage payload: low segments already summed, operands still to be consumed.
    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        stage_flags_t     flags;
    } stage_t;

    stage_t          stage_q [NSEG];
    stage_t          stage_d [NSEG];
    stage_t          head;
    logic [NSEG-1:0] v_q;
    logic [NSEG-1:0] vin;
    logic [NSEG:0]   rdy;

    // Stage 0 input: invert B for subtraction and fold sub into the carry-in.
    always_comb begin
        head             = '0;
        head.a           = a;
        head.b           = sub ? ~b : b;
        head.flags.sub   = sub;
        head.flags.carry = c_in ^ sub;
    end

    // Ready ripples backwards from the consumer; an empty stage is always ready.
    always_comb begin
        rdy       = '0;
        rdy[NSEG] = out_ready;
        for (int k = NSEG - 1; k >= 0; k--) begin
            rdy[k] = !v_q[k] || rdy[k + 1];
        end
    end

    // Valid offered to each stage comes from the previous stage register.
    always_comb begin
        vin    = '0;
        vin[0] = in_valid;
        for (int k = 1; k < NSEG; k++) begin
            vin[k] = v_q[k - 1];
        end
    end

    for (genvar gi = 0; gi < NSEG; gi++) begin : g_stage
        stage_t         cur;
        stage_t         nxt;
        logic [SEG-1:0] seg_sum;
        logic           seg_co;
        logic           seg_cmsb;

        if (gi == 0) begin : g_first
            assign cur = head;
        end else begin : g_rest
            assign cur = stage_q[gi - 1];
        end

        rca_seg #(
            .SEG(SEG)
        ) u_seg (
            .a_i    (cur.a[gi*SEG +: SEG]),
            .b_i    (cur.b[gi*SEG +: SEG]),
            .c_i    (cur.flags.carry),
            .sum_o  (seg_sum),
            .c_o    (seg_co),
            .c_msb_o(seg_cmsb)
        );

        // Merge this segment's result into the payload handed to the next stage.
        always_comb begin
            nxt                        = cur;
            nxt.sum[gi*SEG +: SEG]     = seg_sum;
            nxt.flags.carry            = seg_co;
            nxt.flags.ovf              = seg_cmsb ^ seg_co;
        end

        assign stage_d[gi] = nxt;
    end

    // Stage registers: valid follows ready, payload only loads on a real beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
            for (int k = 0; k < NSEG; k++) begin
                stage_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NSEG; k++) begin
                if (rdy[k]) begin
                    v_q[k] <= vin[k];
                end
                if (rdy[k] && vin[k]) begin
                    stage_q[k] <= stage_d[k];
                end
            end
        end
    end

    assign in_ready  = rdy[0];
    assign out_valid = v_q[NSEG-1];
    assign sum       = stage_q[NSEG-1].sum;
    assign c_out     = stage_q[NSEG-1].flags.carry;
    assign ovf       = stage_q[NSEG-1].flags.ovf;

endmodule

// File: tb/tb_rca_pipe.sv
// Testbench for rca_pipe: directed corner cases on a 32/8 instance and a
// randomized add/sub stream on a 16/4 instance, both against an arithmetic model.
module tb_rca_pipe;

    localparam int W1 = 32;
    localparam int S1 = 8;
    localparam int N1 = W1 / S1;
    localparam int W2 = 16;
    localparam int S2 = 4;
    localparam int N2 = W2 / S2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic          in_valid1, in_ready1, c_in1, sub1, out_valid1, out_ready1, c_out1, ovf1;
    logic [W1-1:0] a1, b1, sum1;
    logic          in_valid2, in_ready2, c_in2, sub2, out_valid2, out_ready2, c_out2, ovf2;
    logic [W2-1:0] a2, b2, sum2;

    int tests = 0;
    int fails = 0;

    typedef struct {
        longint unsigned s;
        bit              co;
        bit              ov;
        int              acc;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];

    rca_pipe #(.WIDTH(W1), .SEG(S1)) dut32 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .c_in(c_in1), .sub(sub1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .sum(sum1), .c_out(c_out1), .ovf(ovf1)
    );

    rca_pipe #(.WIDTH(W2), .SEG(S2)) dut16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid2), .in_ready(in_ready2),
        .a(a2), .b(b2), .c_in(c_in2), .sub(sub2),
        .out_valid(out_valid2), .out_ready(out_ready2),
        .sum(sum2), .c_out(c_out2), .ovf(ovf2)
    );

    // Reference: plain integer arithmetic on unsigned and signed interpretations.
    function automatic exp_t model(input int w, input longint unsigned a, input longint unsigned b,
                                   input bit cin, input bit s);
        exp_t            e;
        longint unsigned m;
        longint          half, sa, sb, sr, ci;
        m    = 64'd1 << w;
        half = longint'(m >> 1);
        ci   = cin ? 64'sd1 : 64'sd0;
        sa   = (a >= (m >> 1)) ? longint'(a) - longint'(m) : longint'(a);
        sb   = (b >= (m >> 1)) ? longint'(b) - longint'(m) : longint'(b);
        if (!s) begin
            e.co = (a + b + cin) >= m;
            e.s  = (a + b + cin) & (m - 1);
            sr   = sa + sb + ci;
        end else begin
            e.co = a >= (b + cin);
            e.s  = (a - b - cin) & (m - 1);
            sr   = sa - sb - ci;
        end
        e.ov  = (sr < -half) || (sr >= half);
        e.acc = 0;
        return e;
    endfunction

    // Offer one beat to the 32-bit instance and wait for its result.
    task automatic beat32(input logic [W1-1:0] a, input logic [W1-1:0] b, input logic cin,
                          input logic s, output logic [W1-1:0] rs, output logic rco,
                          output logic rov, output int lat);
        int g;
        lat = -1; rs = '0; rco = 1'b0; rov = 1'b0; g = 0;
        @(negedge clk);
        a1 = a; b1 = b; c_in1 = cin; sub1 = s; in_valid1 = 1'b1; out_ready1 = 1'b1;
        #1;
        while (!in_ready1 && g < 20) begin
            @(negedge clk); #1; g++;
        end
        @(negedge clk);
        in_valid1 = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            #1;
            if (out_valid1) begin
                lat = c; rs = sum1; rco = c_out1; rov = ovf1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        // Power-on state while reset is held.
        tests++;
        if (out_valid1 !== 1'b0 || sum1 !== '0 || c_out1 !== 1'b0 || ovf1 !== 1'b0) begin
            fails++;
            $display("FAIL reset_hold: got valid=%b sum=%h c=%b o=%b required 0/0/0/0",
                     out_valid1, sum1, c_out1, ovf1);
        end
        @(negedge clk); rst_n = 1'b1; #1;
        tests++;
        if (in_ready1 !== 1'b1 || in_ready2 !== 1'b1) begin
            fails++;
            $display("FAIL reset_ready: got %b/%b required 1/1", in_ready1, in_ready2);
        end
        // Fill the pipe with the consumer stalled, then reset mid-stream.
        out_ready1 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            in_valid1 = 1'b1; a1 = 32'h0000_1234 + i; b1 = 32'h1; c_in1 = 1'b0; sub1 = 1'b0;
        end
        @(negedge clk); in_valid1 = 1'b0; #1;
        tests++;
        if (out_valid1 !== 1'b1 || sum1 !== 32'h0000_1235) begin
            fails++;
            $display("FAIL reset_prefill: got valid=%b sum=%h required 1/00001235", out_valid1, sum1);
        end
        #1 rst_n = 1'b0; #1;
        tests++;
        if (out_valid1 !== 1'b0 || sum1 !== '0 || c_out1 !== 1'b0) begin
            fails++;
            $display("FAIL reset_async: got valid=%b sum=%h c=%b required 0/0/0", out_valid1, sum1, c_out1);
        end
        @(negedge clk); rst_n = 1'b1; out_ready1 = 1'b1; #1;
        tests++;
        if (in_ready1 !== 1'b1) begin
            fails++;
            $display("FAIL reset_release_ready: got %b required 1", in_ready1);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); #1;
            tests++;
            if (out_valid1 !== 1'b0) begin
                fails++;
                $display("FAIL reset_discard: cycle %0d got out_valid=%b required 0", i, out_valid1);
            end
        end
    endtask

    task automatic test_add_wrap();
        logic [W1-1:0] rs; logic rco, rov; int lat;
        beat32(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, rs, rco, rov, lat);
        tests++;
        if (rs !== 32'h0 || rco !== 1'b1 || rov !== 1'b0 || lat != N1) begin
            fails++;
            $display("FAIL add_wrap: got sum=%h c=%b o=%b lat=%0d required 00000000/1/0/%0d",
                     rs, rco, rov, lat, N1);
        end
    endtask

    task automatic test_signed_ovf();
        logic [W1-1:0] rs; logic rco, rov; int lat;
        beat32(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, rs, rco, rov, lat);
        tests++;
        if (rs !== 32'h8000_0000 || rco !== 1'b0 || rov !== 1'b1 || lat != N1) begin
            fails++;
            $display("FAIL signed_ovf: got sum=%h c=%b o=%b lat=%0d required 80000000/0/1/%0d",
                     rs, rco, rov, lat, N1);
        end
    endtask

    task automatic test_sub();
        logic [W1-1:0] rs; logic rco, rov; int lat;
        exp_t e;
        beat32(32'd5, 32'd7, 1'b0, 1'b1, rs, rco, rov, lat);
        tests++;
        if (rs !== 32'hFFFF_FFFE || rco !== 1'b0 || rov !== 1'b0 || lat != N1) begin
            fails++;
            $display("FAIL sub_borrow: got sum=%h c=%b o=%b lat=%0d required fffffffe/0/0/%0d",
                     rs, rco, rov, lat, N1);
        end
        beat32(32'd7, 32'd5, 1'b0, 1'b1, rs, rco, rov, lat);
        tests++;
        if (rs !== 32'h2 || rco !== 1'b1 || rov !== 1'b0 || lat != N1) begin
            fails++;
            $display("FAIL sub_noborrow: got sum=%h c=%b o=%b lat=%0d required 00000002/1/0/%0d",
                     rs, rco, rov, lat, N1);
        end
        // Borrow-in and signed underflow corner.
        beat32(32'h8000_0000, 32'h0000_0000, 1'b1, 1'b1, rs, rco, rov, lat);
        e = model(W1, 64'h8000_0000, 64'h0, 1'b1, 1'b1);
        tests++;
        if (rs !== e.s[W1-1:0] || rco !== e.co || rov !== e.ov) begin
            fails++;
            $display("FAIL sub_borrow_in: got sum=%h c=%b o=%b required %h/%b/%b",
                     rs, rco, rov, e.s[W1-1:0], e.co, e.ov);
        end
    endtask

    task automatic test_backpressure();
        logic [W1-1:0] pa [8];
        logic [W1-1:0] pb [8];
        logic          ps [8];
        logic [W1-1:0] held;
        bit            have_held;
        int            idx, acc_stall, delivered;
        exp_t          e;
        for (int i = 0; i < 8; i++) begin
            pa[i] = $urandom; pb[i] = $urandom; ps[i] = $urandom_range(0, 1);
        end
        idx = 0; acc_stall = 0; delivered = 0; have_held = 0; held = '0;
        q1.delete();
        for (int cyc = 0; cyc < 60 && delivered < 8; cyc++) begin
            @(negedge clk);
            out_ready1 = (cyc >= 6);
            in_valid1  = (idx < 8);
            if (idx < 8) begin
                a1 = pa[idx]; b1 = pb[idx]; sub1 = ps[idx]; c_in1 = idx[0];
            end
            #1;
            if (out_valid1 && !out_ready1) begin
                if (have_held) begin
                    tests++;
                    if (sum1 !== held) begin
                        fails++;
                        $display("FAIL bp_hold: cycle %0d got sum=%h required %h", cyc, sum1, held);
                    end
                end else begin
                    held = sum1; have_held = 1;
                end
            end
            if (in_valid1 && in_ready1) begin
                q1.push_back(model(W1, a1, b1, c_in1, sub1));
                idx++;
                if (cyc < 6) acc_stall++;
            end
            if (out_valid1 && out_ready1) begin
                tests++;
                if (q1.size() == 0) begin
                    fails++;
                    $display("FAIL bp_extra: got unexpected beat sum=%h required none", sum1);
                end else begin
                    e = q1.pop_front();
                    if (sum1 !== e.s[W1-1:0] || c_out1 !== e.co || ovf1 !== e.ov) begin
                        fails++;
                        $display("FAIL bp_data: beat %0d got %h/%b/%b required %h/%b/%b",
                                 delivered, sum1, c_out1, ovf1, e.s[W1-1:0], e.co, e.ov);
                    end
                end
                delivered++;
            end
        end
        in_valid1 = 1'b0;
        tests++;
        if (acc_stall != N1) begin
            fails++;
            $display("FAIL bp_accepts: got %0d accepts during stall required %0d", acc_stall, N1);
        end
        tests++;
        if (delivered != 8 || q1.size() != 0) begin
            fails++;
            $display("FAIL bp_count: got %0d delivered, %0d pending required 8/0", delivered, q1.size());
        end
        @(negedge clk); #1;
        tests++;
        if (out_valid1 !== 1'b0) begin
            fails++;
            $display("FAIL bp_dup: got out_valid=%b after drain required 0", out_valid1);
        end
    endtask

    task automatic test_param16_random();
        exp_t e;
        int   delivered, cyc;
        q2.delete();
        delivered = 0; cyc = 0;
        // Full-rate phase: one beat per cycle, fixed latency.
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            out_ready2 = 1'b1;
            in_valid2  = (i < 20);
            a2 = 16'($urandom); b2 = 16'($urandom);
            c_in2 = 1'($urandom_range(0, 1)); sub2 = 1'($urandom_range(0, 1));
            #1;
            if (i < 20) begin
                tests++;
                if (in_ready2 !== 1'b1) begin
                    fails++;
                    $display("FAIL p16_rate: cycle %0d got in_ready=%b required 1", i, in_ready2);
                end
            end
            if (in_valid2 && in_ready2) begin
                e = model(W2, a2, b2, c_in2, sub2); e.acc = cyc; q2.push_back(e);
            end
            if (out_valid2 && out_ready2 && q2.size() != 0) begin
                e = q2.pop_front();
                tests++;
                if (sum2 !== e.s[W2-1:0] || c_out2 !== e.co || ovf2 !== e.ov || (cyc - e.acc) != N2) begin
                    fails++;
                    $display("FAIL p16_stream: got %h/%b/%b lat=%0d required %h/%b/%b lat=%0d",
                             sum2, c_out2, ovf2, cyc - e.acc, e.s[W2-1:0], e.co, e.ov, N2);
                end
                delivered++;
            end
            cyc++;
        end
        tests++;
        if (delivered != 20) begin
            fails++;
            $display("FAIL p16_throughput: got %0d beats in 24 cycles required 20", delivered);
        end
        // Random valid/ready phase followed by a bounded drain.
        for (int i = 0; i < 340; i++) begin
            @(negedge clk);
            in_valid2  = (i < 300) && ($urandom_range(0, 9) < 8);
            out_ready2 = (i >= 300) || ($urandom_range(0, 3) != 0);
            a2 = 16'($urandom); b2 = 16'($urandom);
            c_in2 = 1'($urandom_range(0, 1)); sub2 = 1'($urandom_range(0, 1));
            #1;
            if (in_valid2 && in_ready2) q2.push_back(model(W2, a2, b2, c_in2, sub2));
            if (out_valid2 && out_ready2) begin
                tests++;
                if (q2.size() == 0) begin
                    fails++;
                    $display("FAIL p16_extra: got unexpected beat sum=%h required none", sum2);
                end else begin
                    e = q2.pop_front();
                    if (sum2 !== e.s[W2-1:0] || c_out2 !== e.co || ovf2 !== e.ov) begin
                        fails++;
                        $display("FAIL p16_random: got %h/%b/%b required %h/%b/%b",
                                 sum2, c_out2, ovf2, e.s[W2-1:0], e.co, e.ov);
                    end
                end
            end
        end
        in_valid2 = 1'b0;
        tests++;
        if (q2.size() != 0 || out_valid2 !== 1'b0) begin
            fails++;
            $display("FAIL p16_drain: got %0d pending, out_valid=%b required 0/0", q2.size(), out_valid2);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid1 = 1'b0; a1 = '0; b1 = '0; c_in1 = 1'b0; sub1 = 1'b0; out_ready1 = 1'b1;
        in_valid2 = 1'b0; a2 = '0; b2 = '0; c_in2 = 1'b0; sub2 = 1'b0; out_ready2 = 1'b1;
        #12;
        test_reset();
        test_add_wrap();
        test_signed_ovf();
        test_sub();
        test_backpressure();
        test_param16_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
